// File: rtl/password_pkg.sv
// Shared message codes, FSM state encoding and LED bit positions for the password sequencer.
package password_pkg;

    typedef enum logic [2:0] {
        MSG_IDLE  = 3'd0,
        MSG_ENTRY = 3'd1,
        MSG_GOOD  = 3'd2,
        MSG_BAD   = 3'd3,
        MSG_LOCK  = 3'd4
    } msg_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_CHECK = 3'd2,
        ST_GOOD  = 3'd3,
        ST_BAD   = 3'd4,
        ST_LOCK  = 3'd5
    } state_e;

    localparam int LED_GOOD = 0;
    localparam int LED_BAD  = 1;
    localparam int LED_LOCK = 2;

    function automatic logic [2:0] led_onehot(input int idx);
        return 3'(1 << idx);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronises and debounces an active-low button, emitting one pulse per accepted press.
// Pulse appears DEBOUNCE_CYCLES+3 cycles after the button falls; releases and short bounces are silent.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic btn_n,
    output logic press_pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_dly_q;
    logic          pulse_q;
    logic [CW-1:0] cnt_q;

    // The counter tracks how long the synchronised input has disagreed with the accepted level.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            level_q     <= 1'b1;
            level_dly_q <= 1'b1;
            pulse_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
            if (sync2_q != level_q) begin
                if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level_q <= sync2_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
            level_dly_q <= level_q;
            pulse_q     <= level_dly_q & ~level_q;
        end
    end

    assign press_pulse = pulse_q;

endmodule

// File: rtl/password_seq_ctrl.sv
// Password entry sequencer: collects digits on confirm presses, checks the code, enforces retries and lockout.
// Outputs are registered one cycle after the accepted press; presses during CHECK and LOCK are dropped.
module password_seq_ctrl
    import password_pkg::*;
#(
    parameter int                      DIGITS          = 4,
    parameter int                      DIG_W           = 4,
    parameter logic [DIGITS*DIG_W-1:0] PASSWORD        = 16'h1234,
    parameter int                      MAX_TRIES       = 3,
    parameter int                      LOCK_CYCLES     = 250_000_000,
    parameter int                      DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             confirm_n,
    input  logic [DIG_W-1:0] digit_in,
    output logic [2:0]       msg_sel,
    output logic [2:0]       digit_count,
    output logic [2:0]       tries_left,
    output logic [2:0]       led,
    output logic             press_pulse
);

    localparam int EW = DIGITS * DIG_W;
    localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    logic          press;
    state_e        state_q;
    msg_e          msg_q;
    logic [EW-1:0] entry_q;
    logic [2:0]    cnt_q;
    logic [2:0]    tries_q;
    logic [2:0]    led_q;
    logic [LW-1:0] lock_cnt_q;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_confirm (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .btn_n      (confirm_n),
        .press_pulse(press)
    );

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            msg_q      <= MSG_IDLE;
            entry_q    <= '0;
            cnt_q      <= 3'd0;
            tries_q    <= 3'(MAX_TRIES);
            led_q      <= 3'b000;
            lock_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (press) begin
                        entry_q <= EW'(digit_in);
                        cnt_q   <= 3'd1;
                        msg_q   <= MSG_ENTRY;
                        state_q <= (DIGITS == 1) ? ST_CHECK : ST_ENTRY;
                    end
                end
                ST_ENTRY: begin
                    if (press) begin
                        entry_q <= (entry_q << DIG_W) | EW'(digit_in);
                        cnt_q   <= cnt_q + 3'd1;
                        if (cnt_q == 3'(DIGITS - 1)) begin
                            state_q <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (entry_q == PASSWORD) begin
                        state_q <= ST_GOOD;
                        msg_q   <= MSG_GOOD;
                        led_q   <= led_onehot(LED_GOOD);
                        tries_q <= 3'(MAX_TRIES);
                    end else if (tries_q <= 3'd1) begin
                        // Last allowed miss: lock rather than show BAD.
                        state_q <= ST_LOCK;
                        msg_q   <= MSG_LOCK;
                        led_q   <= led_onehot(LED_LOCK);
                        tries_q <= 3'd0;
                    end else begin
                        state_q <= ST_BAD;
                        msg_q   <= MSG_BAD;
                        led_q   <= led_onehot(LED_BAD);
                        tries_q <= tries_q - 3'd1;
                    end
                end
                ST_GOOD, ST_BAD: begin
                    if (press) begin
                        state_q <= ST_IDLE;
                        msg_q   <= MSG_IDLE;
                        led_q   <= 3'b000;
                        entry_q <= '0;
                        cnt_q   <= 3'd0;
                    end
                end
                ST_LOCK: begin
                    if (lock_cnt_q == LW'(LOCK_CYCLES - 1)) begin
                        state_q    <= ST_IDLE;
                        msg_q      <= MSG_IDLE;
                        led_q      <= 3'b000;
                        entry_q    <= '0;
                        cnt_q      <= 3'd0;
                        tries_q    <= 3'(MAX_TRIES);
                        lock_cnt_q <= '0;
                    end else begin
                        lock_cnt_q <= lock_cnt_q + LW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    msg_q   <= MSG_IDLE;
                    led_q   <= 3'b000;
                    entry_q <= '0;
                    cnt_q   <= 3'd0;
                end
            endcase
        end
    end

    assign msg_sel     = msg_q;
    assign digit_count = cnt_q;
    assign tries_left  = tries_q;
    assign led         = led_q;
    assign press_pulse = press;

endmodule

// File: tb/tb_password_seq_ctrl.sv
// Randomised scoreboard bench for password_seq_ctrl against a digit-queue reference model.
module tb_password_seq_ctrl;

    localparam int          DIGITS      = 4;
    localparam int          DIG_W       = 4;
    localparam logic [15:0] PASSWORD    = 16'h1234;
    localparam int          MAX_TRIES   = 3;
    localparam int          LOCK_CYCLES = 100;
    localparam int          DEB         = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       confirm_n;
    logic [3:0] digit_in;
    logic [2:0] msg_sel;
    logic [2:0] digit_count;
    logic [2:0] tries_left;
    logic [2:0] led;
    logic       press_pulse;

    password_seq_ctrl #(
        .DIGITS         (DIGITS),
        .DIG_W          (DIG_W),
        .PASSWORD       (PASSWORD),
        .MAX_TRIES      (MAX_TRIES),
        .LOCK_CYCLES    (LOCK_CYCLES),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .CLOCK_50   (clk),
        .reset      (rst),
        .confirm_n  (confirm_n),
        .digit_in   (digit_in),
        .msg_sel    (msg_sel),
        .digit_count(digit_count),
        .tries_left (tries_left),
        .led        (led),
        .press_pulse(press_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] msg;
        logic [2:0] cnt;
        logic [2:0] tries;
        logic [2:0] led;
    } exp_t;

    exp_t expq[$];

    // Reference model: mode uses the display message codes directly.
    int m_mode;
    int m_tries;
    int m_digits[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t model_view();
        exp_t r;
        r.msg   = 3'(m_mode);
        r.cnt   = 3'(m_digits.size());
        r.tries = 3'(m_tries);
        r.led   = (m_mode == 2) ? 3'b001 : (m_mode == 3) ? 3'b010 : (m_mode == 4) ? 3'b100 : 3'b000;
        return r;
    endfunction

    function automatic void model_reset();
        m_mode  = 0;
        m_tries = MAX_TRIES;
        m_digits.delete();
    endfunction

    function automatic exp_t model_press(input int d);
        int code;
        if (m_mode == 0 || m_mode == 1) begin
            m_digits.push_back(d);
            if (m_digits.size() == DIGITS) begin
                code = 0;
                foreach (m_digits[i]) code = code * 16 + m_digits[i];
                if (code == int'(PASSWORD)) begin
                    m_mode  = 2;
                    m_tries = MAX_TRIES;
                end else begin
                    m_tries = m_tries - 1;
                    m_mode  = (m_tries == 0) ? 4 : 3;
                end
            end else begin
                m_mode = 1;
            end
        end else if (m_mode == 2 || m_mode == 3) begin
            m_mode = 0;
            m_digits.delete();
        end
        return model_view();
    endfunction

    // Monitor: every accepted press must match the next queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && press_pulse) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_press_pulse: got pulse, expected none (cycle %0d)", cyc);
                end else begin
                    e = expq.pop_front();
                    @(negedge clk);
                    chk("pulse_width", press_pulse, 0);
                    chk("count_next_cycle", digit_count, e.cnt);
                    @(negedge clk);
                    chk("msg_sel", msg_sel, e.msg);
                    chk("digit_count", digit_count, e.cnt);
                    chk("tries_left", tries_left, e.tries);
                    chk("led", led, e.led);
                end
            end
        end
    end

    int lock_run = 0;
    int lock_last = 0;
    always @(negedge clk) begin
        if (msg_sel == 3'd4) lock_run = lock_run + 1;
        else if (lock_run != 0) begin
            lock_last = lock_run;
            lock_run  = 0;
        end
    end

    task automatic press(input logic [3:0] d);
        int  c0;
        bit  seen;
        expq.push_back(model_press(int'(d)));
        @(posedge clk);
        #1;
        digit_in  = d;
        confirm_n = 1'b0;
        c0        = cyc;
        seen      = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (press_pulse) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL press_timeout: got no pulse, expected one within 40 cycles");
        end else begin
            chk("press_latency", cyc - c0, DEB + 3);
        end
        repeat (3) @(negedge clk);
        digit_in = 4'($urandom);
        repeat (4) @(negedge clk);
        confirm_n = 1'b1;
        repeat (DEB + 8) @(negedge clk);
    endtask

    task automatic bouncy_press(input logic [3:0] d);
        expq.push_back(model_press(int'(d)));
        @(negedge clk);
        digit_in  = d;
        confirm_n = 1'b0;
        repeat (2) @(negedge clk);
        confirm_n = 1'b1;
        @(negedge clk);
        confirm_n = 1'b0;
        repeat (12) @(negedge clk);
        digit_in  = 4'($urandom);
        confirm_n = 1'b1;
        repeat (DEB + 8) @(negedge clk);
        chk("bounce_single_pulse", expq.size(), 0);
    endtask

    task automatic enter_code(input logic [15:0] code);
        for (int i = DIGITS - 1; i >= 0; i--) press(code[i*4 +: 4]);
    endtask

    task automatic apply_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_msg_sel", msg_sel, 0);
        chk("rst_digit_count", digit_count, 0);
        chk("rst_tries_left", tries_left, MAX_TRIES);
        chk("rst_led", led, 0);
        chk("rst_press_pulse", press_pulse, 0);
        model_reset();
        expq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic ride_out_lock(input int presses);
        bit done;
        for (int i = 0; i < presses; i++) press(4'($urandom));
        done = 1'b0;
        for (int i = 0; i < 4 * LOCK_CYCLES && !done; i++) begin
            @(negedge clk);
            if (msg_sel != 3'd4) done = 1'b1;
        end
        @(negedge clk);
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL lock_expiry_timeout: got msg_sel %0d, expected lock to end", msg_sel);
        end else begin
            chk("lock_duration", lock_last, LOCK_CYCLES);
        end
        model_reset();
        chk("unlock_msg_sel", msg_sel, 0);
        chk("unlock_tries_left", tries_left, MAX_TRIES);
        chk("unlock_led", led, 0);
        chk("unlock_digit_count", digit_count, 0);
    endtask

    task automatic wrong_until_lock();
        for (int n = 0; n < MAX_TRIES + 1 && m_mode != 4; n++) begin
            enter_code(16'h1235);
            if (m_mode == 3) press(4'h0);
        end
    endtask

    logic [15:0] code;

    initial begin
        rst       = 1'b0;
        confirm_n = 1'b1;
        digit_in  = 4'h0;
        model_reset();
        apply_reset();
        repeat (3) @(negedge clk);

        enter_code(16'h1234);
        press(4'h9);
        enter_code(16'h1235);
        press(4'h1);

        wrong_until_lock();
        ride_out_lock(2);

        bouncy_press(4'h7);
        press(4'h3);
        apply_reset();

        wrong_until_lock();
        repeat (20) @(negedge clk);
        apply_reset();
        repeat (3) @(negedge clk);

        for (int k = 0; k < 10; k++) begin
            if ($urandom_range(0, 1) == 0) code = PASSWORD;
            else code = 16'($urandom);
            enter_code(code);
            if (m_mode == 2 || m_mode == 3) press(4'($urandom));
            else if (m_mode == 4) ride_out_lock(1);
        end

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1);
    end

endmodule
